// File: rtl/wb_banked_ram_pkg.sv
// Shared types and helpers for the banked dual-port Wishbone RAM.
package wb_banked_ram_pkg;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_e;

  // Request fields are sized for the largest supported configuration.
  localparam int MAX_WORD_W = 32;
  localparam int MAX_DATA_W = 256;
  localparam int MAX_SEL_W  = 32;

  typedef struct packed {
    logic                  we;
    logic [MAX_WORD_W-1:0] word;
    logic [MAX_DATA_W-1:0] data;
    logic [MAX_SEL_W-1:0]  sel;
  } wb_req_t;

  function automatic logic [31:0] bank_of(input logic [31:0] addr,
                                          input int unsigned addr_w,
                                          input int unsigned bank_bits);
    logic [31:0] mask;
    if (bank_bits == 0) return '0;
    mask = (32'd1 << bank_bits) - 32'd1;
    return (addr >> (addr_w - bank_bits)) & mask;
  endfunction

endpackage

// File: rtl/wb_banked_ram_bank.sv
// Single-port byte-writable synchronous RAM bank with one-cycle read latency.
module ram_bank #(
  parameter int WORDS  = 1024,
  parameter int DATA_W = 32,
  localparam int AW    = $clog2(WORDS),
  localparam int SW    = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic              we_i,
  input  logic [AW-1:0]     addr_i,
  input  logic [SW-1:0]     be_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [WORDS];
  logic [DATA_W-1:0] rdata_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      for (int i = 0; i < SW; i++) begin
        if (be_i[i]) mem_q[addr_i][i*8 +: 8] <= wdata_i[i*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rdata_q <= '0;
    else if (en_i && !we_i) rdata_q <= mem_q[addr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_banked_ram.sv
// Dual-port pipelined Wishbone RAM over N_BANKS single-port banks with per-bank arbitration.
// Define WB_BANKED_RAM_RR_ARB_EN for round-robin conflicts; otherwise port A always wins.
module wb_banked_ram
  import wb_banked_ram_pkg::*;
#(
  parameter int N_BANKS        = 2,
  parameter int WORDS_PER_BANK = 1024,
  parameter int DATA_W         = 32,
  parameter int ADDR_W         = $clog2(N_BANKS * WORDS_PER_BANK),
  parameter int SEL_W          = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              pa_wb_cyc_i,
  input  logic              pa_wb_stb_i,
  input  logic              pa_wb_we_i,
  input  logic [ADDR_W-1:0] pa_wb_addr_i,
  input  logic [DATA_W-1:0] pa_wb_data_i,
  input  logic [SEL_W-1:0]  pa_wb_sel_i,
  output logic              pa_wb_ack_o,
  output logic              pa_wb_stall_o,
  output logic [DATA_W-1:0] pa_wb_data_o,
  input  logic              pb_wb_cyc_i,
  input  logic              pb_wb_stb_i,
  input  logic              pb_wb_we_i,
  input  logic [ADDR_W-1:0] pb_wb_addr_i,
  input  logic [DATA_W-1:0] pb_wb_data_i,
  input  logic [SEL_W-1:0]  pb_wb_sel_i,
  output logic              pb_wb_ack_o,
  output logic              pb_wb_stall_o,
  output logic [DATA_W-1:0] pb_wb_data_o
);

  localparam int BANK_BITS = $clog2(N_BANKS);
  localparam int WORD_W    = $clog2(WORDS_PER_BANK);
  localparam int BIDX_W    = (BANK_BITS > 0) ? BANK_BITS : 1;

  wb_req_t             req_a, req_b;
  logic                req_a_v, req_b_v, acc_a, acc_b;
  logic [BIDX_W-1:0]   bank_a, bank_b;
  logic [N_BANKS-1:0]  conflict, a_win;
  logic [DATA_W-1:0]   bank_rdata [N_BANKS];
  logic                ack_a_q, ack_b_q, rd_a_q, rd_b_q;
  logic [BIDX_W-1:0]   bidx_a_q, bidx_b_q;
  logic                unused_req;

  always_comb begin
    req_a      = '0;
    req_a.we   = pa_wb_we_i;
    req_a.word = MAX_WORD_W'(pa_wb_addr_i[WORD_W-1:0]);
    req_a.data = MAX_DATA_W'(pa_wb_data_i);
    req_a.sel  = MAX_SEL_W'(pa_wb_sel_i);
    req_b      = '0;
    req_b.we   = pb_wb_we_i;
    req_b.word = MAX_WORD_W'(pb_wb_addr_i[WORD_W-1:0]);
    req_b.data = MAX_DATA_W'(pb_wb_data_i);
    req_b.sel  = MAX_SEL_W'(pb_wb_sel_i);
  end

  assign unused_req = ^{req_a, req_b};

  assign req_a_v = pa_wb_cyc_i & pa_wb_stb_i;
  assign req_b_v = pb_wb_cyc_i & pb_wb_stb_i;
  assign bank_a  = BIDX_W'(bank_of(32'(pa_wb_addr_i), ADDR_W, BANK_BITS));
  assign bank_b  = BIDX_W'(bank_of(32'(pb_wb_addr_i), ADDR_W, BANK_BITS));

  assign pa_wb_stall_o = req_a_v & conflict[bank_a] & ~a_win[bank_a];
  assign pb_wb_stall_o = req_b_v & conflict[bank_b] &  a_win[bank_b];
  assign acc_a = req_a_v & ~pa_wb_stall_o;
  assign acc_b = req_b_v & ~pb_wb_stall_o;

  for (genvar g = 0; g < N_BANKS; g++) begin : g_bank
    logic a_hit, b_hit, use_a, use_b;

    assign a_hit       = req_a_v && (bank_a == BIDX_W'(g));
    assign b_hit       = req_b_v && (bank_b == BIDX_W'(g));
    assign conflict[g] = a_hit & b_hit;

`ifdef WB_BANKED_RAM_RR_ARB_EN
    port_e last_grant_q;

    // A conflict goes to the port that did not win the previous conflict.
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) last_grant_q <= PORT_B;
      else if (conflict[g]) last_grant_q <= (last_grant_q == PORT_B) ? PORT_A : PORT_B;
    end

    assign a_win[g] = (last_grant_q == PORT_B);
`else
    assign a_win[g] = 1'b1;
`endif

    assign use_a = a_hit & (~b_hit | a_win[g]);
    assign use_b = b_hit & ~use_a;

    ram_bank #(
      .WORDS  (WORDS_PER_BANK),
      .DATA_W (DATA_W)
    ) u_bank (
      .clk_i   (clk_i),
      .rst_ni  (rst_ni),
      .en_i    (use_a | use_b),
      .we_i    (use_a ? req_a.we : req_b.we),
      .addr_i  (use_a ? req_a.word[WORD_W-1:0] : req_b.word[WORD_W-1:0]),
      .be_i    (use_a ? req_a.sel[SEL_W-1:0] : req_b.sel[SEL_W-1:0]),
      .wdata_i (use_a ? req_a.data[DATA_W-1:0] : req_b.data[DATA_W-1:0]),
      .rdata_o (bank_rdata[g])
    );
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ack_a_q  <= 1'b0;
      ack_b_q  <= 1'b0;
      rd_a_q   <= 1'b0;
      rd_b_q   <= 1'b0;
      bidx_a_q <= '0;
      bidx_b_q <= '0;
    end else begin
      ack_a_q  <= acc_a;
      ack_b_q  <= acc_b;
      rd_a_q   <= acc_a & ~pa_wb_we_i;
      rd_b_q   <= acc_b & ~pb_wb_we_i;
      bidx_a_q <= bank_a;
      bidx_b_q <= bank_b;
    end
  end

  // Dropping cyc in the ack cycle aborts the transfer and hides the ack.
  assign pa_wb_ack_o  = ack_a_q & pa_wb_cyc_i;
  assign pb_wb_ack_o  = ack_b_q & pb_wb_cyc_i;
  assign pa_wb_data_o = (pa_wb_ack_o && rd_a_q) ? bank_rdata[bidx_a_q] : '0;
  assign pb_wb_data_o = (pb_wb_ack_o && rd_b_q) ? bank_rdata[bidx_b_q] : '0;

endmodule

// File: tb/tb_wb_banked_ram.sv
// Directed bench for wb_banked_ram: per-port access, byte lanes, bank parallelism, conflicts, abort, reset.
module tb_wb_banked_ram;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 11;
  localparam int SEL_W  = 4;
`ifdef WB_BANKED_RAM_RR_ARB_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic              clk, rst_n;
  logic              a_cyc, a_stb, a_we, a_ack, a_stall;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdat, a_rdat;
  logic [SEL_W-1:0]  a_sel;
  logic              b_cyc, b_stb, b_we, b_ack, b_stall;
  logic [ADDR_W-1:0] b_addr;
  logic [DATA_W-1:0] b_wdat, b_rdat;
  logic [SEL_W-1:0]  b_sel;
  int                total, bad;

  wb_banked_ram dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .pa_wb_cyc_i   (a_cyc),
    .pa_wb_stb_i   (a_stb),
    .pa_wb_we_i    (a_we),
    .pa_wb_addr_i  (a_addr),
    .pa_wb_data_i  (a_wdat),
    .pa_wb_sel_i   (a_sel),
    .pa_wb_ack_o   (a_ack),
    .pa_wb_stall_o (a_stall),
    .pa_wb_data_o  (a_rdat),
    .pb_wb_cyc_i   (b_cyc),
    .pb_wb_stb_i   (b_stb),
    .pb_wb_we_i    (b_we),
    .pb_wb_addr_i  (b_addr),
    .pb_wb_data_i  (b_wdat),
    .pb_wb_sel_i   (b_sel),
    .pb_wb_ack_o   (b_ack),
    .pb_wb_stall_o (b_stall),
    .pb_wb_data_o  (b_rdat)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks
  task automatic drive_a(input logic cyc, input logic stb, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] dat,
                         input logic [SEL_W-1:0] sel);
    a_cyc = cyc; a_stb = stb; a_we = we; a_addr = addr; a_wdat = dat; a_sel = sel;
  endtask

  task automatic drive_b(input logic cyc, input logic stb, input logic we,
                         input logic [ADDR_W-1:0] addr, input logic [DATA_W-1:0] dat,
                         input logic [SEL_W-1:0] sel);
    b_cyc = cyc; b_stb = stb; b_we = we; b_addr = addr; b_wdat = dat; b_sel = sel;
  endtask

  task automatic idle_a(); drive_a(1'b1, 1'b0, 1'b0, '0, '0, '0); endtask
  task automatic idle_b(); drive_b(1'b1, 1'b0, 1'b0, '0, '0, '0); endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [DATA_W-1:0] obs, input logic [DATA_W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    drive_a(1'b0, 1'b0, 1'b0, '0, '0, '0);
    drive_b(1'b0, 1'b0, 1'b0, '0, '0, '0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ack_a", 32'(a_ack), 32'd0);
    chk("rst_ack_b", 32'(b_ack), 32'd0);
    chk("rst_data_a", a_rdat, 32'h0);
    chk("rst_data_b", b_rdat, 32'h0);
    chk("rst_stall_a", 32'(a_stall), 32'd0);
    rst_n = 1'b1;

    // 1: write/read on each port
    next_cycle(); drive_a(1, 1, 1, 11'd4, 32'hDEADBEEF, 4'hF);
    @(negedge clk); chk("wr_a_stall", 32'(a_stall), 0); chk("wr_a_noack_early", 32'(a_ack), 0);
    next_cycle(); drive_a(1, 1, 0, 11'd4, '0, '0);
    @(negedge clk); chk("wr_a_ack", 32'(a_ack), 1);
    next_cycle(); idle_a();
    @(negedge clk); chk("rd_a_ack", 32'(a_ack), 1); chk("rd_a_data", a_rdat, 32'hDEADBEEF);
    next_cycle();
    @(negedge clk); chk("rd_a_ack_pulse", 32'(a_ack), 0);
    drive_b(1, 1, 1, 11'd1026, 32'hBEEFCAFE, 4'hF);
    next_cycle(); drive_b(1, 1, 0, 11'd1026, '0, '0);
    @(negedge clk); chk("wr_b_ack", 32'(b_ack), 1);
    next_cycle(); idle_b();
    @(negedge clk); chk("rd_b_ack", 32'(b_ack), 1); chk("rd_b_data", b_rdat, 32'hBEEFCAFE);

    // 2: byte enables
    next_cycle(); drive_a(1, 1, 1, 11'd10, 32'hAABBCCDD, 4'hF);
    next_cycle(); drive_a(1, 1, 1, 11'd10, 32'h00001122, 4'b0011);
    next_cycle(); drive_a(1, 1, 0, 11'd10, '0, '0);
    next_cycle(); idle_a();
    @(negedge clk); chk("sel_ack", 32'(a_ack), 1); chk("sel_data", a_rdat, 32'hAABB1122);

    // 3: parallel banks
    next_cycle(); drive_a(1, 1, 1, 11'd100, 32'h0A0A0100, 4'hF); drive_b(1, 1, 1, 11'd1224, 32'h0B0B1224, 4'hF);
    @(negedge clk); chk("par_wr_stall_a", 32'(a_stall), 0); chk("par_wr_stall_b", 32'(b_stall), 0);
    next_cycle(); drive_a(1, 1, 0, 11'd100, '0, '0); drive_b(1, 1, 0, 11'd1224, '0, '0);
    @(negedge clk); chk("par_rd_stall_a", 32'(a_stall), 0); chk("par_rd_stall_b", 32'(b_stall), 0);
    next_cycle(); idle_a(); idle_b();
    @(negedge clk);
    chk("par_ack_a", 32'(a_ack), 1); chk("par_ack_b", 32'(b_ack), 1);
    chk("par_data_a", a_rdat, 32'h0A0A0100); chk("par_data_b", b_rdat, 32'h0B0B1224);

    // 4: same-bank conflicts
    next_cycle(); drive_a(1, 1, 1, 11'd5, 32'h55555555, 4'hF);
    next_cycle(); drive_a(1, 1, 1, 11'd6, 32'h66666666, 4'hF);
    next_cycle(); idle_a();
    next_cycle(); drive_a(1, 1, 0, 11'd5, '0, '0); drive_b(1, 1, 0, 11'd6, '0, '0);
    @(negedge clk); chk("c1_stall_a", 32'(a_stall), 0); chk("c1_stall_b", 32'(b_stall), 1);
    next_cycle(); idle_a();
    @(negedge clk);
    chk("c1_b_retry_stall", 32'(b_stall), 0); chk("c1_ack_a", 32'(a_ack), 1);
    chk("c1_data_a", a_rdat, 32'h55555555); chk("c1_ack_b_early", 32'(b_ack), 0);
    next_cycle(); idle_b();
    @(negedge clk); chk("c1_ack_b", 32'(b_ack), 1); chk("c1_data_b", b_rdat, 32'h66666666);
    next_cycle(); drive_a(1, 1, 0, 11'd5, '0, '0); drive_b(1, 1, 0, 11'd6, '0, '0);
    @(negedge clk); chk("c2_stall_a", 32'(a_stall), 32'(RR)); chk("c2_stall_b", 32'(b_stall), 32'(!RR));
    next_cycle();
    if (RR) idle_b(); else idle_a();
    @(negedge clk);
    chk("c2_retry_stall_a", 32'(a_stall), 0); chk("c2_retry_stall_b", 32'(b_stall), 0);
    chk("c2_win_ack_a", 32'(a_ack), 32'(!RR)); chk("c2_win_ack_b", 32'(b_ack), 32'(RR));
    next_cycle(); idle_a(); idle_b();
    @(negedge clk);
    chk("c2_lose_ack_a", 32'(a_ack), 32'(RR)); chk("c2_lose_ack_b", 32'(b_ack), 32'(!RR));
    chk("c2_lose_data", RR ? a_rdat : b_rdat, RR ? 32'h55555555 : 32'h66666666);

    // 5: same-address write race, first conflict after reset
    pulse_reset();
    next_cycle(); drive_a(1, 1, 1, 11'd20, 32'h11111111, 4'hF); drive_b(1, 1, 1, 11'd20, 32'h22222222, 4'hF);
    @(negedge clk); chk("race_stall_a", 32'(a_stall), 0); chk("race_stall_b", 32'(b_stall), 1);
    next_cycle(); idle_a();
    @(negedge clk); chk("race_b_retry_stall", 32'(b_stall), 0); chk("race_ack_a", 32'(a_ack), 1);
    next_cycle(); idle_b(); drive_a(1, 1, 0, 11'd20, '0, '0);
    @(negedge clk); chk("race_ack_b", 32'(b_ack), 1);
    next_cycle(); idle_a();
    @(negedge clk); chk("race_rd_ack", 32'(a_ack), 1); chk("race_rd_data", a_rdat, 32'h22222222);

    // 6a: abort by dropping cyc in the ack cycle
    next_cycle(); drive_a(1, 1, 0, 11'd4, '0, '0);
    next_cycle(); drive_a(0, 0, 0, '0, '0, '0);
    @(negedge clk); chk("abort_ack", 32'(a_ack), 0);
    next_cycle(); idle_a();
    @(negedge clk); chk("abort_no_late_ack", 32'(a_ack), 0);

    // 6b: reset in the middle of a read
    next_cycle(); drive_a(1, 1, 0, 11'd4, '0, '0);
    next_cycle(); idle_a();
    #1; chk("mid_pre_ack", 32'(a_ack), 1);
    rst_n = 1'b0;
    #1; chk("mid_rst_ack", 32'(a_ack), 0); chk("mid_rst_data", a_rdat, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    next_cycle(); drive_a(1, 1, 0, 11'd4, '0, '0);
    next_cycle(); idle_a();
    @(negedge clk); chk("post_rst_ack", 32'(a_ack), 1); chk("post_rst_data", a_rdat, 32'hDEADBEEF);

    next_cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
